// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect and decode slots.
// master = fetch queue side, slave = memory/decode/commit side.
interface inst_fetch_queue_if #(
  parameter int unsigned AW = 3
);
  logic [31:0] inst_address;
  logic        InstMem_Read;
  logic        InstMem_Ready;
  logic [31:0] inst1_in;
  logic [31:0] inst2_in;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic [1:0]  Dec_Valid;
  logic [31:0] Dec_Inst_1;
  logic [31:0] Dec_Inst_2;
  logic [31:0] Dec_PC_1;
  logic [31:0] Dec_PC_2;
  logic [1:0]  Dec_Take;
  logic [AW:0] Queue_Count;

  modport master (
    output inst_address, InstMem_Read,
    input  InstMem_Ready, inst1_in, inst2_in,
    input  Redirect_Valid, Redirect_PC,
    output Dec_Valid, Dec_Inst_1, Dec_Inst_2, Dec_PC_1, Dec_PC_2,
    input  Dec_Take,
    output Queue_Count
  );

  modport slave (
    input  inst_address, InstMem_Read,
    output InstMem_Ready, inst1_in, inst2_in,
    output Redirect_Valid, Redirect_PC,
    input  Dec_Valid, Dec_Inst_1, Dec_Inst_2, Dec_PC_1, Dec_PC_2,
    output Dec_Take,
    input  Queue_Count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-word instruction fetch queue: fetch PC, circular {PC,inst} buffer, two decode slots.
// Optional same-cycle fetch-to-decode bypass on an empty queue: define FETCH_BYPASS_EN.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam logic [AW+1:0] DepthW = (AW+2)'(DEPTH);

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic [1:0]    avail;
  logic [1:0]    take_eff;
  logic [AW+1:0] free_after;
  logic          read;
  logic          hit;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  logic          wr0_en, wr1_en;
  logic [AW-1:0] wr0_idx, wr1_idx;
  logic [31:0]   wr0_inst, wr1_inst, wr0_pc, wr1_pc;

`ifdef FETCH_BYPASS_EN
  logic          bypass_act;
  logic [1:0]    bypass_take;
`endif

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Only entries actually present can be consumed; an empty queue ignores Dec_Take.
  always_comb begin
    avail    = (count_q >= (AW+1)'(2)) ? 2'd2 : count_q[1:0];
    take_eff = (bus.Dec_Take > avail) ? avail : bus.Dec_Take;
  end

  assign free_after = DepthW - {1'b0, count_q} + {{AW{1'b0}}, take_eff};
  assign read       = !rst && !bus.Redirect_Valid && (free_after >= (AW+2)'(2));
  assign hit        = read && bus.InstMem_Ready;

`ifdef FETCH_BYPASS_EN
  assign bypass_act  = hit && (count_q == '0);
  assign bypass_take = (bus.Dec_Take == 2'd3) ? 2'd2 : bus.Dec_Take;
`endif

  // Next-state and write-port selection.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    wr0_en     = 1'b0;
    wr1_en     = 1'b0;
    wr0_idx    = tail_q;
    wr1_idx    = tail_p1;
    wr0_inst   = bus.inst1_in;
    wr1_inst   = bus.inst2_in;
    wr0_pc     = fetch_pc_q;
    wr1_pc     = fetch_pc_q + 32'd4;

    if (bus.Redirect_Valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.Redirect_PC & 32'hFFFF_FFFC;
    end else begin
      head_d  = head_q + AW'(take_eff);
      count_d = count_q - (AW+1)'(take_eff);
      if (hit) begin
        wr0_en     = 1'b1;
        wr1_en     = 1'b1;
        tail_d     = tail_q + AW'(2);
        count_d    = count_q - (AW+1)'(take_eff) + (AW+1)'(2);
        fetch_pc_d = fetch_pc_q + 32'd8;
      end
`ifdef FETCH_BYPASS_EN
      // Words consumed straight from memory never occupy a queue slot.
      if (bypass_act) begin
        head_d = head_q;
        unique case (bypass_take)
          2'd0: begin
            tail_d  = tail_q + AW'(2);
            count_d = (AW+1)'(2);
          end
          2'd1: begin
            wr1_en   = 1'b0;
            wr0_inst = bus.inst2_in;
            wr0_pc   = fetch_pc_q + 32'd4;
            tail_d   = tail_p1;
            count_d  = (AW+1)'(1);
          end
          default: begin
            wr0_en  = 1'b0;
            wr1_en  = 1'b0;
            tail_d  = tail_q;
            count_d = '0;
          end
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      inst_mem_q[wr0_idx] <= wr0_inst;
      pc_mem_q[wr0_idx]   <= wr0_pc;
    end
    if (wr1_en) begin
      inst_mem_q[wr1_idx] <= wr1_inst;
      pc_mem_q[wr1_idx]   <= wr1_pc;
    end
  end

  always_comb begin
    bus.inst_address = fetch_pc_q;
    bus.InstMem_Read = read;
    bus.Queue_Count  = count_q;
    bus.Dec_Inst_1   = inst_mem_q[head_q];
    bus.Dec_Inst_2   = inst_mem_q[head_p1];
    bus.Dec_PC_1     = pc_mem_q[head_q];
    bus.Dec_PC_2     = pc_mem_q[head_p1];
    if (count_q >= (AW+1)'(2)) begin
      bus.Dec_Valid = 2'b11;
    end else if (count_q == (AW+1)'(1)) begin
      bus.Dec_Valid = 2'b01;
    end else begin
      bus.Dec_Valid = 2'b00;
    end
`ifdef FETCH_BYPASS_EN
    if (bypass_act) begin
      bus.Dec_Valid  = 2'b11;
      bus.Dec_Inst_1 = bus.inst1_in;
      bus.Dec_Inst_2 = bus.inst2_in;
      bus.Dec_PC_1   = fetch_pc_q;
      bus.Dec_PC_2   = fetch_pc_q + 32'd4;
    end
`endif
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int Depth = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.AW(3)) bus ();

  inst_fetch_queue #(.DEPTH(8), .AW(3), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hDEAD_BEEF ^ {a[31:16], 16'h0};
  endfunction

  assign bus.inst1_in = mem_word(bus.inst_address);
  assign bus.inst2_in = mem_word(bus.inst_address + 32'd4);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  int          passed = 0;
  int          total  = 0;

  logic        cur_hit, cur_redir;
  logic [1:0]  cur_take;
  logic [31:0] cur_rpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Drive one cycle's inputs and compare every output with the model before the edge.
  task automatic apply(input logic rdy, input logic [1:0] take, input logic redir,
                       input logic [31:0] rpc);
    int size, te;
    logic er;
    logic [1:0] ev;
    logic [31:0] p1, p2, i1, i2;
    bus.InstMem_Ready  = rdy;
    bus.Dec_Take       = take;
    bus.Redirect_Valid = redir;
    bus.Redirect_PC    = rpc;
    #3;
    size = q.size();
    te   = (size == 0) ? 0 : ((int'(take) > size) ? size : int'(take));
    er   = !redir && (Depth - size + te >= 2);
    if (Byp && size == 0 && er && rdy) begin
      ev = 2'b11;
      p1 = mpc;
      p2 = mpc + 32'd4;
      i1 = mem_word(p1);
      i2 = mem_word(p2);
    end else begin
      ev = (size >= 2) ? 2'b11 : (size == 1) ? 2'b01 : 2'b00;
      p1 = (size >= 1) ? q[0].pc : 32'h0;
      i1 = (size >= 1) ? q[0].inst : 32'h0;
      p2 = (size >= 2) ? q[1].pc : 32'h0;
      i2 = (size >= 2) ? q[1].inst : 32'h0;
    end
    check("read", {31'h0, bus.InstMem_Read}, {31'h0, er});
    check("addr", bus.inst_address, mpc);
    check("count", {28'h0, bus.Queue_Count}, size);
    check("valid", {30'h0, bus.Dec_Valid}, {30'h0, ev});
    if (ev[0]) begin
      check("pc1", bus.Dec_PC_1, p1);
      check("inst1", bus.Dec_Inst_1, i1);
    end
    if (ev[1]) begin
      check("pc2", bus.Dec_PC_2, p2);
      check("inst2", bus.Dec_Inst_2, i2);
    end
    cur_hit   = er && rdy;
    cur_take  = take;
    cur_redir = redir;
    cur_rpc   = rpc;
  endtask

  task automatic push_pair(input logic [31:0] pc);
    ent_t e;
    e.pc = pc;      e.inst = mem_word(pc);      q.push_back(e);
    e.pc = pc + 4;  e.inst = mem_word(pc + 4);  q.push_back(e);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) void'(q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cur_redir) begin
      q.delete();
      mpc = cur_rpc & 32'hFFFF_FFFC;
    end else if (Byp) begin
      if (cur_hit) push_pair(mpc);
      pop_n(int'(cur_take));
      if (cur_hit) mpc = mpc + 32'd8;
    end else begin
      pop_n(int'(cur_take));
      if (cur_hit) begin
        push_pair(mpc);
        mpc = mpc + 32'd8;
      end
    end
  endtask

  typedef struct {
    logic        rdy;
    logic [1:0]  take;
    logic        exp_read;
    logic [31:0] exp_addr;
    int          exp_count;
    logic [1:0]  exp_valid;
    logic        chk_pc;
    logic [31:0] exp_pc1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int avail;
    logic rdy, redir;
    logic [1:0] take;

    tbl[0] = '{1'b1, 2'd0, 1'b1, 32'd0,  0, (Byp ? 2'b11 : 2'b00), 1'b0, 32'd0};
    tbl[1] = '{1'b1, 2'd0, 1'b1, 32'd8,  2, 2'b11, 1'b1, 32'd0};
    tbl[2] = '{1'b1, 2'd0, 1'b1, 32'd16, 4, 2'b11, 1'b1, 32'd0};
    tbl[3] = '{1'b1, 2'd0, 1'b1, 32'd24, 6, 2'b11, 1'b1, 32'd0};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 32'd32, 8, 2'b11, 1'b1, 32'd0};
    tbl[5] = '{1'b1, 2'd1, 1'b0, 32'd32, 8, 2'b11, 1'b1, 32'd0};
    tbl[6] = '{1'b1, 2'd1, 1'b1, 32'd32, 7, 2'b11, 1'b1, 32'd4};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 32'd40, 8, 2'b11, 1'b1, 32'd8};
    tbl[8] = '{1'b1, 2'd2, 1'b1, 32'd40, 8, 2'b11, 1'b1, 32'd8};
    tbl[9] = '{1'b1, 2'd2, 1'b1, 32'd48, 8, 2'b11, 1'b1, 32'd16};

    bus.InstMem_Ready  = 1'b1;
    bus.Dec_Take       = 2'd0;
    bus.Redirect_Valid = 1'b0;
    bus.Redirect_PC    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", {31'h0, bus.InstMem_Read}, 32'h0);
    check("rst_count", {28'h0, bus.Queue_Count}, 32'h0);
    check("rst_valid", {30'h0, bus.Dec_Valid}, 32'h0);
    check("rst_addr", bus.inst_address, 32'h0);
    rst = 1'b0;
    q.delete();
    mpc = 32'h0;

    // Fill to full, then drain one at a time across the full boundary.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].rdy, tbl[i].take, 1'b0, 32'h0);
      check($sformatf("tbl%0d_read", i), {31'h0, bus.InstMem_Read}, {31'h0, tbl[i].exp_read});
      check($sformatf("tbl%0d_addr", i), bus.inst_address, tbl[i].exp_addr);
      check($sformatf("tbl%0d_count", i), {28'h0, bus.Queue_Count}, tbl[i].exp_count);
      check($sformatf("tbl%0d_valid", i), {30'h0, bus.Dec_Valid}, {30'h0, tbl[i].exp_valid});
      if (tbl[i].chk_pc) check($sformatf("tbl%0d_pc1", i), bus.Dec_PC_1, tbl[i].exp_pc1);
      tick();
    end

    // Steady state at two per cycle.
    apply(1'b1, 2'd0, 1'b1, 32'h0);
    tick();
    apply(1'b1, 2'd0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 2'd2, 1'b0, 32'h0);
      check("steady_pc1", bus.Dec_PC_1, 32'(8 * i));
      check("steady_count", {28'h0, bus.Queue_Count}, 32'd2);
      tick();
    end

    // Redirect with five entries resident: old words must vanish.
    apply(1'b1, 2'd0, 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'd0, 1'b0, 32'h0);
      tick();
    end
    apply(1'b0, 2'd1, 1'b0, 32'h0);
    tick();
    apply(1'b1, 2'd1, 1'b1, 32'h400);
    check("redir_count5", {28'h0, bus.Queue_Count}, 32'd5);
    check("redir_read0", {31'h0, bus.InstMem_Read}, 32'h0);
    tick();
    apply(1'b0, 2'd0, 1'b0, 32'h0);
    check("post_redir_count", {28'h0, bus.Queue_Count}, 32'd0);
    check("post_redir_valid", {30'h0, bus.Dec_Valid}, 32'd0);
    check("post_redir_addr", bus.inst_address, 32'h400);
    tick();
    apply(1'b1, 2'd0, 1'b0, 32'h0);
    tick();
    apply(1'b0, 2'd0, 1'b0, 32'h0);
    check("redir_first_pc", bus.Dec_PC_1, 32'h400);
    tick();

    // Memory stall while decode drains.
    apply(1'b1, 2'd0, 1'b1, 32'h100);
    tick();
    apply(1'b1, 2'd0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, (i < 2) ? 2'd1 : 2'd0, 1'b0, 32'h0);
      check("stall_addr", bus.inst_address, 32'h108);
      check("stall_valid", {30'h0, bus.Dec_Valid}, (i == 0) ? 32'd3 : (i == 1) ? 32'd1 : 32'd0);
      tick();
    end

`ifdef FETCH_BYPASS_EN
    apply(1'b1, 2'd0, 1'b1, 32'h40);
    tick();
    apply(1'b1, 2'd1, 1'b0, 32'h0);
    check("byp_pc1", bus.Dec_PC_1, 32'h40);
    check("byp_valid", {30'h0, bus.Dec_Valid}, 32'd3);
    tick();
    apply(1'b0, 2'd0, 1'b0, 32'h0);
    check("byp_count", {28'h0, bus.Queue_Count}, 32'd1);
    check("byp_next_pc1", bus.Dec_PC_1, 32'h44);
    tick();
`endif

    // Asynchronous reset between edges.
    apply(1'b1, 2'd0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_count", {28'h0, bus.Queue_Count}, 32'd0);
    check("async_rst_valid", {30'h0, bus.Dec_Valid}, 32'd0);
    check("async_rst_read", {31'h0, bus.InstMem_Read}, 32'd0);
    check("async_rst_addr", bus.inst_address, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mpc = 32'h0;

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      if (q.size() == 0) avail = (Byp && rdy && !redir) ? 2 : 0;
      else avail = (q.size() >= 2) ? 2 : 1;
      take = 2'($urandom_range(0, avail));
      apply(rdy, take, redir, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
